// File: rtl/damped_resonator_pkg.sv
// Shared types, constants and saturation helpers for the damped resonator bank.
package damped_resonator_pkg;

    localparam int STATE_W_DEF = 40;
    localparam int COEF_W_DEF  = 34;
    localparam int FRAC_W      = 32;                  // Q2.32 coefficients
    localparam int OUT_W_DEF   = 17;
    localparam int MID         = 2 ** (OUT_W_DEF - 2); // offset-binary zero
    localparam int ACC_W       = 128;                 // wide scratch for sums before saturation

    typedef logic signed [STATE_W_DEF-1:0] state_t;
    typedef logic        [COEF_W_DEF-1:0]  coef_t;
    typedef logic signed [ACC_W-1:0]       acc_t;

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, MUL_C, FINISH} fsm_t;

    // Symmetric saturation to +/-(2^(w-1)-1); the most negative code is never produced.
    function automatic acc_t sat_state(input acc_t v, input int w);
        acc_t lim;
        lim = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Clamp an output code into [lo, 2^w-1].
    function automatic acc_t clamp_out(input acc_t v, input int w, input acc_t lo);
        acc_t hi;
        hi = (acc_t'(1) <<< w) - acc_t'(1);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/damped_resonator_mac.sv
// Shared multiplier for all channels: operands are picked by the FSM phase,
// the intermediate "would" and new-last terms are held here between phases.
module resonator_mac
    import damped_resonator_pkg::*;
#(
    parameter int STATE_W    = 40,
    parameter int COEF_W     = 34,
    parameter int IN_W       = 4,
    parameter int KICK_SHIFT = 17
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  fsm_t                      i_phase,
    input  logic signed [STATE_W-1:0] i_cur,
    input  logic signed [STATE_W-1:0] i_last,
    input  logic        [COEF_W-1:0]  i_cos2,
    input  logic        [COEF_W-1:0]  i_damp,
    input  logic        [IN_W-1:0]    i_in,
    input  logic        [IN_W-1:0]    i_last_in,
    output logic signed [STATE_W-1:0] o_cur,
    output logic signed [STATE_W-1:0] o_last
);

    // cos2 < 4 so p fits in STATE_W+2 bits; subtracting last needs one more.
    localparam int A_W = STATE_W + 3;
    localparam int P_W = A_W + COEF_W + 1;

    logic signed [A_W-1:0]     r_would;
    logic signed [STATE_W-1:0] r_new_last;
    logic signed [A_W-1:0]     w_opa;
    logic        [COEF_W-1:0]  w_opb;
    logic signed [P_W-1:0]     w_prod;
    logic signed [P_W-1:0]     w_q;
    logic signed [IN_W:0]      w_change;
    acc_t                      w_sum;

    // Operand select: cos2*cur in MUL_A, cur*damp in MUL_B, would*damp in MUL_C.
    always_comb begin
        w_opa = A_W'(i_cur);
        w_opb = i_cos2;
        case (i_phase)
            MUL_B:   w_opb = i_damp;
            MUL_C: begin
                w_opa = r_would;
                w_opb = i_damp;
            end
            default: ;
        endcase
    end

    assign w_prod   = P_W'(w_opa) * P_W'($signed({1'b0, w_opb}));
    assign w_q      = w_prod >>> FRAC_W;
    assign w_change = $signed({1'b0, i_last_in}) - $signed({1'b0, i_in});
    assign w_sum    = acc_t'(w_q) + (acc_t'(w_change) <<< KICK_SHIFT);
    assign o_cur    = STATE_W'(sat_state(w_sum, STATE_W));
    assign o_last   = r_new_last;

    // Hold the MUL_A and MUL_B results for the commit in MUL_C.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_would    <= '0;
            r_new_last <= '0;
        end else begin
            case (i_phase)
                MUL_A:   r_would    <= A_W'(w_q) - A_W'(i_last);
                MUL_B:   r_new_last <= STATE_W'(sat_state(acc_t'(w_q), STATE_W));
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/damped_resonator_bank.sv
// N-channel damped two-pole resonator bank sharing one multiplier,
// sequenced once per 48 kHz strobe; produces per-channel and mixed outputs.
module damped_resonator_bank
    import damped_resonator_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IN_W       = 4,
    parameter int STATE_W    = 40,
    parameter int COEF_W     = 34,
    parameter int KICK_SHIFT = 17,
    parameter int OUT_W      = 17,
    parameter int OUT_SHIFT  = 12,
    parameter int FLOOR      = 28672,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en_48KHz,
    input  logic [NUM_CH*IN_W-1:0]   ctrl,
    input  logic [NUM_CH*COEF_W-1:0] cos2_coef,
    input  logic [NUM_CH*COEF_W-1:0] damp_coef,
    input  logic [NUM_CH-1:0]        mute,
    output logic [NUM_CH*OUT_W-1:0]  out_ch,
    output logic [OUT_W-1:0]         out_mix,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int   CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam acc_t W_MID = acc_t'(2 ** (OUT_W - 2));
    localparam acc_t W_LO  = acc_t'(FLOOR);

    fsm_t                      r_state, w_state_nxt;
    logic [CH_W-1:0]           r_ch;
    logic [NUM_CH*IN_W-1:0]    r_ctrl;
    logic [NUM_CH*COEF_W-1:0]  r_cos2, r_damp;
    logic [NUM_CH-1:0]         r_mute;
    logic signed [STATE_W-1:0] r_cur  [NUM_CH];
    logic signed [STATE_W-1:0] r_last [NUM_CH];
    logic [IN_W-1:0]           r_last_in [NUM_CH];
    logic [NUM_CH*OUT_W-1:0]   r_out_ch;
    logic [OUT_W-1:0]          r_out_mix;
    logic                      r_overrun;

    logic [IN_W-1:0]           w_in;
    logic [COEF_W-1:0]         w_cos2, w_damp;
    logic signed [STATE_W-1:0] w_mac_cur, w_mac_last;
    logic [NUM_CH*OUT_W-1:0]   w_out_ch;
    logic [OUT_W-1:0]          w_out_mix;
    acc_t                      w_sh, w_sum;

    assign w_in   = r_ctrl[int'(r_ch)*IN_W +: IN_W];
    assign w_cos2 = r_cos2[int'(r_ch)*COEF_W +: COEF_W];
    assign w_damp = r_damp[int'(r_ch)*COEF_W +: COEF_W];

    resonator_mac #(
        .STATE_W    (STATE_W),
        .COEF_W     (COEF_W),
        .IN_W       (IN_W),
        .KICK_SHIFT (KICK_SHIFT)
    ) u_mac (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_phase   (r_state),
        .i_cur     (r_cur[r_ch]),
        .i_last    (r_last[r_ch]),
        .i_cos2    (w_cos2),
        .i_damp    (w_damp),
        .i_in      (w_in),
        .i_last_in (r_last_in[r_ch]),
        .o_cur     (w_mac_cur),
        .o_last    (w_mac_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: three multiply phases per channel, then one FINISH cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clk_en_48KHz) w_state_nxt = MUL_A;
            MUL_A:   w_state_nxt = MUL_B;
            MUL_B:   w_state_nxt = MUL_C;
            MUL_C:   w_state_nxt = (r_ch == CH_W'(NUM_CH - 1)) ? FINISH : MUL_A;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output codes from committed state: offset-binary, clamped to [FLOOR, 2^OUT_W-1].
    always_comb begin
        w_sh     = '0;
        w_sum    = '0;
        w_out_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sh  = acc_t'(r_cur[k] >>> OUT_SHIFT);
            w_sum = w_sum + w_sh;
            w_out_ch[k*OUT_W +: OUT_W] = OUT_W'(clamp_out(W_MID + w_sh, OUT_W, W_LO));
        end
        w_out_mix = OUT_W'(clamp_out(W_MID + (w_sum >>> MIX_SHIFT), OUT_W, W_LO));
    end

    // Latch inputs on an accepted strobe, commit per channel in MUL_C, publish in FINISH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch      <= '0;
            r_ctrl    <= '0;
            r_cos2    <= '0;
            r_damp    <= '0;
            r_mute    <= '0;
            r_out_ch  <= {NUM_CH{OUT_W'(2 ** (OUT_W - 2))}};
            r_out_mix <= OUT_W'(2 ** (OUT_W - 2));
            r_overrun <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cur[k]     <= '0;
                r_last[k]    <= '0;
                r_last_in[k] <= '0;
            end
        end else begin
            if (clk_en_48KHz) begin
                if (r_state == IDLE) begin
                    r_ctrl <= ctrl;
                    r_cos2 <= cos2_coef;
                    r_damp <= damp_coef;
                    r_mute <= mute;
                    r_ch   <= '0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (r_state == MUL_C) begin
                // Muted channels still track last_in so unmuting does not kick.
                r_cur[r_ch]     <= r_mute[r_ch] ? '0 : w_mac_cur;
                r_last[r_ch]    <= r_mute[r_ch] ? '0 : w_mac_last;
                r_last_in[r_ch] <= w_in;
                if (r_ch != CH_W'(NUM_CH - 1)) r_ch <= r_ch + CH_W'(1);
            end
            if (r_state == FINISH) begin
                r_out_ch  <= w_out_ch;
                r_out_mix <= w_out_mix;
            end
        end
    end

    assign out_ch    = r_out_ch;
    assign out_mix   = r_out_mix;
    assign out_valid = (r_state == FINISH);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_damped_resonator_bank.sv
// Directed bench: main instance plus two parameter variants for clamp/saturation cases.
module tb_damped_resonator_bank;

    localparam int NCH = 4;
    localparam int IW  = 4;
    localparam int CW  = 34;
    localparam int OW  = 17;
    localparam logic [CW-1:0] COS2 = 34'd8589026053;
    localparam logic [CW-1:0] DAMP = 34'd4292359648;
    localparam logic [OW-1:0] MIDC = 17'd32768;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic [NCH*IW-1:0] ctrl = '0;
    logic [NCH*CW-1:0] cos2 = '0;
    logic [NCH*CW-1:0] damp = '0;
    logic [NCH-1:0]    mute = '0;

    logic [NCH*OW-1:0] m_ch, k_ch, s_ch;
    logic [OW-1:0]     m_mix, k_mix, s_mix;
    logic              m_vld, k_vld, s_vld, m_ovr, k_ovr, s_ovr;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    damped_resonator_bank u_dut (
        .clk(clk), .reset(reset), .clk_en_48KHz(en), .ctrl(ctrl), .cos2_coef(cos2),
        .damp_coef(damp), .mute(mute), .out_ch(m_ch), .out_mix(m_mix),
        .out_valid(m_vld), .overrun(m_ovr));

    damped_resonator_bank #(.KICK_SHIFT(22)) u_k22 (
        .clk(clk), .reset(reset), .clk_en_48KHz(en), .ctrl(ctrl), .cos2_coef(cos2),
        .damp_coef(damp), .mute(mute), .out_ch(k_ch), .out_mix(k_mix),
        .out_valid(k_vld), .overrun(k_ovr));

    damped_resonator_bank #(.STATE_W(30), .KICK_SHIFT(26)) u_s30 (
        .clk(clk), .reset(reset), .clk_en_48KHz(en), .ctrl(ctrl), .cos2_coef(cos2),
        .damp_coef(damp), .mute(mute), .out_ch(s_ch), .out_mix(s_mix),
        .out_valid(s_vld), .overrun(s_ovr));

    task automatic do_reset();
        en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pulse the strobe for one clk; returns at the negedge of cycle 1.
    task automatic strobe();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Counts cycles to out_valid (bounded), then steps to the cycle where outputs are updated.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!m_vld && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (m_ch !== {NCH{MIDC}}) $display("FAIL reset_out_ch got %h exp %h", m_ch, {NCH{MIDC}}); else n_pass++;
        n_chk++; if (m_mix !== MIDC) $display("FAIL reset_out_mix got %0d exp %0d", m_mix, MIDC); else n_pass++;
        n_chk++; if (m_vld !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", m_vld); else n_pass++;
        n_chk++; if (m_ovr !== 1'b0) $display("FAIL reset_overrun got %b exp 0", m_ovr); else n_pass++;
    endtask

    task automatic test_idle_strobe();
        int lat;
        ctrl = '0;
        cos2 = {NCH{COS2}};
        damp = {NCH{DAMP}};
        strobe();
        wait_valid(lat);
        n_chk++; if (lat != 13) $display("FAIL idle_latency got %0d exp 13", lat); else n_pass++;
        n_chk++; if (m_ch !== {NCH{MIDC}}) $display("FAIL idle_out_ch got %h exp %h", m_ch, {NCH{MIDC}}); else n_pass++;
        n_chk++; if (m_mix !== MIDC) $display("FAIL idle_out_mix got %0d exp %0d", m_mix, MIDC); else n_pass++;
        n_chk++; if (m_vld !== 1'b0 || m_ovr !== 1'b0) $display("FAIL idle_pulse_ovr got vld=%b ovr=%b exp 0 0", m_vld, m_ovr); else n_pass++;
    endtask

    task automatic test_kick_ring();
        int lat;
        do_reset();
        cos2 = {NCH{COS2}};
        damp = {NCH{DAMP}};
        ctrl = 16'h000F;
        strobe();
        // Inputs changed after the latch must not affect this sequence.
        cos2 = '0;
        damp = '0;
        ctrl = '0;
        wait_valid(lat);
        n_chk++; if (m_ch !== {MIDC, MIDC, MIDC, 17'd32288}) $display("FAIL kick_out_ch got %h exp ch0=32288", m_ch); else n_pass++;
        n_chk++; if (m_mix !== 17'd32648) $display("FAIL kick_out_mix got %0d exp 32648", m_mix); else n_pass++;
        n_chk++; if (k_ch[OW-1:0] !== 17'd28672) $display("FAIL k22_floor got %0d exp 28672", k_ch[OW-1:0]); else n_pass++;
        n_chk++; if (k_mix !== 17'd28928) $display("FAIL k22_mix got %0d exp 28928", k_mix); else n_pass++;
        n_chk++; if (s_ch[OW-1:0] !== 17'd28672 || s_mix !== 17'd28672) $display("FAIL s30_neg_sat got ch0=%0d mix=%0d exp 28672 28672", s_ch[OW-1:0], s_mix); else n_pass++;
        // Second sample: no kick, state rings from cur=-1966080, last=0.
        cos2 = {NCH{COS2}};
        damp = {NCH{DAMP}};
        ctrl = 16'h000F;
        strobe();
        wait_valid(lat);
        n_chk++; if (m_ch[OW-1:0] !== 17'd31808) $display("FAIL ring_out_ch0 got %0d exp 31808", m_ch[OW-1:0]); else n_pass++;
        n_chk++; if (m_mix !== 17'd32528) $display("FAIL ring_out_mix got %0d exp 32528", m_mix); else n_pass++;
    endtask

    task automatic test_mute();
        int lat;
        mute = 4'b0001;
        strobe();
        wait_valid(lat);
        n_chk++; if (m_ch !== {NCH{MIDC}}) $display("FAIL mute_out_ch got %h exp %h", m_ch, {NCH{MIDC}}); else n_pass++;
        n_chk++; if (k_ch[OW-1:0] !== MIDC || s_ch[OW-1:0] !== MIDC) $display("FAIL mute_variants got k=%0d s=%0d exp 32768", k_ch[OW-1:0], s_ch[OW-1:0]); else n_pass++;
        mute = 4'b0000;
        strobe();
        wait_valid(lat);
        n_chk++; if (m_ch !== {NCH{MIDC}} || m_mix !== MIDC) $display("FAIL unmute_no_kick got ch=%h mix=%0d exp all 32768", m_ch, m_mix); else n_pass++;
        ctrl = 16'h0000;
        strobe();
        wait_valid(lat);
        n_chk++; if (m_ch[OW-1:0] !== 17'd33248) $display("FAIL pos_kick_ch0 got %0d exp 33248", m_ch[OW-1:0]); else n_pass++;
        n_chk++; if (m_mix !== 17'd32888) $display("FAIL pos_kick_mix got %0d exp 32888", m_mix); else n_pass++;
        n_chk++; if (k_ch[OW-1:0] !== 17'd48128 || k_mix !== 17'd36608) $display("FAIL k22_pos got ch0=%0d mix=%0d exp 48128 36608", k_ch[OW-1:0], k_mix); else n_pass++;
        n_chk++; if (s_ch[OW-1:0] !== 17'd131071) $display("FAIL s30_pos_sat got %0d exp 131071", s_ch[OW-1:0]); else n_pass++;
        n_chk++; if (s_mix !== 17'd65535) $display("FAIL s30_pos_mix got %0d exp 65535", s_mix); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        ctrl = 16'h000F;
        strobe();
        @(negedge clk);       // cycle 2, busy in MUL_B
        ctrl = 16'h0000;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (m_vld) pulses++;
            @(negedge clk);
        end
        n_chk++; if (pulses != 1) $display("FAIL b2b_pulses got %0d exp 1", pulses); else n_pass++;
        n_chk++; if (m_ovr !== 1'b1) $display("FAIL b2b_overrun got %b exp 1", m_ovr); else n_pass++;
        n_chk++; if (m_ch[OW-1:0] !== 17'd32288) $display("FAIL b2b_out_ch0 got %0d exp 32288", m_ch[OW-1:0]); else n_pass++;
    endtask

    task automatic test_finish_strobe();
        int lat;
        int pulses;
        do_reset();
        ctrl = 16'h0000;
        strobe();
        lat = 1;
        while (!m_vld && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        en = 1'b1;            // lands on the FINISH cycle
        @(negedge clk);
        en = 1'b0;
        n_chk++; if (m_ovr !== 1'b1) $display("FAIL finish_overrun got %b exp 1", m_ovr); else n_pass++;
        pulses = 0;
        repeat (30) begin
            if (m_vld) pulses++;
            @(negedge clk);
        end
        n_chk++; if (pulses != 0) $display("FAIL finish_not_accepted got %0d pulses exp 0", pulses); else n_pass++;
        ctrl = 16'h000F;
        strobe();
        wait_valid(lat);
        n_chk++; if (lat != 13) $display("FAIL after_finish_latency got %0d exp 13", lat); else n_pass++;
        n_chk++; if (m_ch[OW-1:0] !== 17'd32288) $display("FAIL after_finish_ch0 got %0d exp 32288", m_ch[OW-1:0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        ctrl = 16'h0000;
        strobe();
        @(negedge clk);       // cycle 2, ch0 in MUL_B
        reset = 1'b1;
        #1;
        n_chk++; if (m_ch !== {NCH{MIDC}}) $display("FAIL midreset_out_ch got %h exp %h", m_ch, {NCH{MIDC}}); else n_pass++;
        n_chk++; if (m_mix !== MIDC || m_ovr !== 1'b0 || m_vld !== 1'b0) $display("FAIL midreset_misc got mix=%0d ovr=%b vld=%b exp 32768 0 0", m_mix, m_ovr, m_vld); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        ctrl = 16'h000F;
        strobe();
        wait_valid(lat);
        n_chk++; if (m_ch[OW-1:0] !== 17'd32288) $display("FAIL midreset_fresh_kick got %0d exp 32288", m_ch[OW-1:0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_strobe();
        test_kick_ring();
        test_mute();
        test_back_to_back();
        test_finish_strobe();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim time exceeded");
        $fatal(1);
    end

endmodule

// File: doc/damped_resonator_bank.md
Name: damped_resonator_bank

Overview:
- Multi-channel successor to the single-channel crash/bang resonator.
- Each channel runs a damped two-pole sine recurrence, kicked by steps on its control nibble. All channels share one multiplier, time-multiplexed once per sample strobe.
- Produces per-channel offset-binary outputs and a saturated mix. Sits between the sound-latch decode and the audio mixer.
- New relative to the single-channel version: N channels, per-channel runtime coefficients, mute, two-sided saturation and an overrun flag.

Parameters:
- NUM_CH, 4, number of resonator channels.
- IN_W, 4, control input width per channel.
- STATE_W, 40, signed width of the cur/last sample state.
- COEF_W, 34, unsigned coefficient width, Q2.32 (frac bits = 32).
- KICK_SHIFT, 17, left shift applied to the input step.
- OUT_W, 17, output width.
- OUT_SHIFT, 12, right shift from state to output.
- FLOOR, 28672, minimum output code (2^15-2^12).
- MIX_SHIFT, 2, right shift of the channel sum before the mix offset is added.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- clk_en_48KHz, in, 1, sample strobe; one clk wide.
- ctrl, in, NUM_CH*IN_W, per-channel control nibbles (crash level).
- cos2_coef, in, NUM_CH*COEF_W, 2*cos(omega) per channel, Q2.32.
- damp_coef, in, NUM_CH*COEF_W, per-sample damping ratio, Q2.32, must be <1.0.
- mute, in, NUM_CH, forces the channel state to zero while high.
- out_ch, out, NUM_CH*OUT_W, per-channel outputs.
- out_mix, out, OUT_W, mixed output.
- out_valid, out, 1, one-cycle pulse when the outputs update.
- overrun, out, 1, sticky; set when a strobe arrives while busy.

Behaviour:
- Reset (async): cur/last of all channels = 0; last_in = 0; FSM in IDLE; out_ch each = 2^(OUT_W-2) (32768); out_mix = 32768; out_valid = 0; overrun = 0.
- FSM states are IDLE, MUL_A, MUL_B, MUL_C, FINISH.
- IDLE:
  - On a strobe, latch ctrl, cos2_coef, damp_coef and mute for all channels; ch = 0; go to MUL_A.
- MUL_A: p = (cos2 * cur) >>> 32; would = p - last.
- MUL_B: new_last = (cur * damp) >>> 32.
- MUL_C:
  - change = signed(last_in) - signed(in), using zero-extended nibbles.
  - new_cur = ((would * damp) >>> 32) + (change <<< KICK_SHIFT).
  - Commit cur and last; last_in = in.
  - If ch == NUM_CH-1, go to FINISH; otherwise ch++ and go to MUL_A.
- Mute: when mute[ch] is latched high, MUL_C commits cur = last = 0. last_in still updates, so no kick is produced on unmute.
- FINISH:
  - out_ch[k] = clamp(32768 + (cur_k >>> OUT_SHIFT), FLOOR, 2^OUT_W - 1).
  - out_mix = clamp(32768 + (sum of (cur_k >>> OUT_SHIFT)) >>> MIX_SHIFT, FLOOR, 2^OUT_W - 1).
  - out_valid = 1 for this cycle; return to IDLE.
- Latency: strobe at cycle 0; channel k occupies cycles 1+3k through 3+3k; FINISH and out_valid at cycle 3*NUM_CH+1. Outputs are updated at cycle 3*NUM_CH+2 and hold between updates.
- Arithmetic:
  - Products are computed at full width (STATE_W + COEF_W) with an arithmetic shift.
  - Committed cur/last saturate to ±(2^(STATE_W-1)-1); no wrap-around.
- Strobe while not in IDLE: ignored (no re-latch), overrun set. overrun clears only on reset.
- Strobe in the same cycle as FINISH: not accepted; it counts as an overrun.
- Coefficient or ctrl changes between strobes have no effect until the next strobe latch.
- Reset mid-sequence: all state returns to reset values immediately; no partial commit survives.

Decomposition:
- Package damped_resonator_pkg contains:
  - typedefs state_t (signed STATE_W) and coef_t;
  - the FSM state enum;
  - the constant MID = 2^(OUT_W-2);
  - functions sat_state() and clamp_out().
- Sub-module resonator_mac: combinational/registered shared multiply, Q2.32 shift and add with state saturation, selected by the FSM phase.

Test Plan:
- Reset, then one strobe with ctrl all 0 -> out_valid at cycle 3*NUM_CH+1; all outputs 32768; overrun 0.
- ch0 ctrl 0->15 at strobe, cos2 = 8589026053, damp = 4292359648 -> cur0 = -1966080; out_ch[0] = 32288; other channels 32768.
- Same ch0 with ctrl 15->0 -> cur0 = +1966080; out_ch[0] = 33248. Next strobes oscillate with decaying amplitude; after 48000 strobes |cur0| < 2^OUT_SHIFT.
- KICK_SHIFT = 22 with a 0->15 step -> cur0 = -62914560; out_ch[0] clamps to FLOOR = 28672. With a 15->0 step at STATE_W = 30 -> state saturates with no sign flip, and the output clamps to 131071.
- Second strobe 2 cycles after the first -> overrun = 1; only one out_valid pulse; results equal the single-strobe case.
- ch0 ringing, mute[0] = 1 for one strobe -> out_ch[0] = 32768; after unmute with unchanged ctrl it stays 32768. Reset asserted mid-MUL_B -> outputs are 32768 immediately.
